// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter that shares the register file write port among NUM_REQ
// valid/ready requesters; the winner is registered, and writes to R0 are dropped and counted.
module regfile_write_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int CNT_W   = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [5*NUM_REQ-1:0]  req_addr,
   input  logic [32*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]    req_ready,
   output logic                  wr_en,
   output logic [4:0]            wr_addr,
   output logic [31:0]           wr_data,
   output logic [2:0]            grant_id,
   output logic [CNT_W-1:0]      r0_drop_count,
   output logic                  busy
);

   localparam int               PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic             wr_en_q, wr_en_d;
   logic [4:0]       wr_addr_q, wr_addr_d;
   logic [31:0]      wr_data_q, wr_data_d;
   logic [2:0]       grant_id_q, grant_id_d;
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

   logic             gnt_vld_s;
   logic [PTR_W-1:0] gnt_idx_s;
   logic [4:0]       sel_addr_s;
   logic [31:0]      sel_data_s;
   int               cand_s;

   // Grant search starts at the pointer; ready never looks at payload.
   always_comb begin
      gnt_vld_s = 1'b0;
      gnt_idx_s = '0;
      cand_s    = 0;
      req_ready = '0;
      if (rst_n && enable) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            cand_s = (int'(ptr_q) + k) % NUM_REQ;
            if (!gnt_vld_s && req_valid[cand_s]) begin
               gnt_vld_s = 1'b1;
               gnt_idx_s = PTR_W'(cand_s);
            end else begin
               gnt_idx_s = gnt_idx_s;
            end
         end
         req_ready[gnt_idx_s] = gnt_vld_s;
      end else begin
         req_ready = '0;
      end
   end

   // Payload mux for the winning requester
   always_comb begin
      sel_addr_s = req_addr[5*gnt_idx_s +: 5];
      sel_data_s = req_data[32*gnt_idx_s +: 32];
   end

   // Next-state: pointer advance, write stage load, saturating R0 drop count
   always_comb begin
      ptr_d      = ptr_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      grant_id_d = grant_id_q;
      drop_cnt_d = drop_cnt_q;
      if (gnt_vld_s) begin
         ptr_d = (gnt_idx_s == LAST_IDX) ? '0 : gnt_idx_s + PTR_W'(1);
         if (sel_addr_s != 5'd0) begin
            wr_en_d    = 1'b1;
            wr_addr_d  = sel_addr_s;
            wr_data_d  = sel_data_s;
            grant_id_d = 3'(gnt_idx_s);
         end else if (drop_cnt_q != CNT_MAX) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
         end else begin
            drop_cnt_d = drop_cnt_q;
         end
      end else begin
         ptr_d = ptr_q;
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_q      <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= 5'd0;
         wr_data_q  <= 32'd0;
         grant_id_q <= 3'd0;
         drop_cnt_q <= '0;
      end else begin
         ptr_q      <= ptr_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         grant_id_q <= grant_id_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign wr_en         = wr_en_q;
   assign wr_addr       = wr_addr_q;
   assign wr_data       = wr_data_q;
   assign grant_id      = grant_id_q;
   assign r0_drop_count = drop_cnt_q;
   assign busy          = |req_valid;

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Shares the register file's single write port among NUM_REQ writeback requesters, for example ALU result, load return, multiply/divide unit and debug port. Each requester uses a valid/ready handshake. Arbitration is round-robin. The winning request is registered and presented to the register file write port one cycle later. Writes addressed to R0 are accepted, dropped and counted, matching the hardwired-zero R0.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
CNT_W, 16, width of the saturating R0-drop counter

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
enable  input  1  arbitration enable; 0 = freeze grants
req_valid  input  NUM_REQ  per-requester write request
req_addr  input  5*NUM_REQ  register address; requester i at [5i+4:5i]
req_data  input  32*NUM_REQ  write data; requester i at [32i+31:32i]
req_ready  output  NUM_REQ  one-hot grant / accept, combinational
wr_en  output  1  register file write enable
wr_addr  output  5  register file write address
wr_data  output  32  register file write data
grant_id  output  3  index of requester that produced current wr_* (valid when wr_en=1)
r0_drop_count  output  CNT_W  count of accepted R0 writes, saturating
busy  output  1  any req_valid asserted this cycle

Behaviour:
- Reset is synchronous on the clk edge with rst_n=0.
  - Outputs and state on reset: wr_en=0, wr_addr=0, wr_data=0, grant_id=0, r0_drop_count=0, rr pointer=0.
  - req_ready is 0 while rst_n=0.
  - A reset mid-operation discards any registered write; nothing is written in the following cycle.
- Handshake:
  - A transfer occurs on the clk edge where req_valid[i] and req_ready[i] are both 1.
  - The requester holds valid and payload stable until accepted. The arbiter does not depend on this.
  - At most one req_ready bit is high per cycle.
  - req_ready[i] is a combinational function of req_valid, rr pointer, enable and rst_n only. It never depends on payload.
- Arbitration:
  - The search starts at the rr pointer p and proceeds p, p+1, ..., wrapping modulo NUM_REQ. The first valid requester wins.
  - After a grant to i, p <= (i+1) mod NUM_REQ. With no grant, p holds.
  - enable=0: all req_ready=0, p holds, wr_en=0 on the next edge.
- Write stage, 1-cycle latency:
  - On an accepted transfer from i with addr≠0: next cycle wr_en=1, wr_addr=addr, wr_data=data, grant_id=i.
  - On an accepted transfer with addr=0: next cycle wr_en=0, and r0_drop_count increments, saturating at 2^CNT_W−1.
  - With no transfer: next cycle wr_en=0. wr_addr, wr_data and grant_id hold their previous values.
- Back-to-back: one write per cycle sustained. With all requesters continuously valid, grants rotate 0,1,2,3,0,… with no idle cycles.
- Same address from two requesters in one cycle: only the round-robin winner is accepted. The other stays pending and writes on a later cycle, so the last writer wins in grant order.
- Fairness: a continuously valid requester waits at most NUM_REQ−1 cycles for a grant while enable=1.
- busy = |req_valid, combinational.

Test Plan:
- Reset, then a single request: req 0 valid, addr=5, data=0xDEADBEEF. Required: req_ready[0]=1 in the same cycle; next cycle wr_en=1, wr_addr=5, wr_data=0xDEADBEEF, grant_id=0. Assert rst_n=0 for one cycle mid-stream: wr_en=0 and all outputs 0 on the following cycle.
- All 4 requesters valid for 8 cycles, addrs 1..4. Required: grants 0,1,2,3,0,1,2,3; wr_en high for 8 consecutive cycles starting 1 cycle after the first grant; pointer returns to 0.
- R0 drop: requester 2 writes addr=0 three times, data=0x12345678. Required: 3 handshakes, wr_en stays 0, r0_drop_count=3. With CNT_W forced to 2, seven drops leave the count at 3 (saturation).
- Collision: req 1 and req 3 both addr=7 (data 0xAAAA0001 and 0xAAAA0003), pointer=2. Required: req 3 granted first, req 1 the next cycle; final wr sequence 0xAAAA0003 then 0xAAAA0001.
- Freeze: enable=0 for 3 cycles with req 0 valid. Required: req_ready=0 and wr_en=0 for that window, pointer unchanged. On re-enable, req 0 is granted in the first enabled cycle.
- Starvation check, random valid patterns for 10k cycles. Required: no requester waits more than 3 cycles while valid and enable=1; the scoreboard of expected register contents matches wr_* traffic exactly.
